enm_bullet_pool: RTL and testbench
==================================

ENM_BULLET_POOL -- requirements
Module: enm_bullet_pool

Interface
REQ-001 Parameter N_ENM, default 4: number of enemies; bullet count NB = 3*N_ENM.
REQ-002 Parameter FIRE_PERIOD, default 16: clk22 cycles between volleys per enemy (range 2..255).
REQ-003 Parameter SPD_V, default 10: straight-bullet y step per cycle.
REQ-004 Parameter SPD_D, default 7: diagonal-bullet x and y step per cycle.
REQ-005 Parameters X_MIN 8, X_MAX 432, Y_MAX 472: playfield bounds.
REQ-006 clk22  in  1  game tick clock; sole clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 reimux, reimuy  in  10 each  player centre.
REQ-009 enmx, enmy  in  10*N_ENM each  packed enemy positions; enemy e at bits [10e+9:10e].
REQ-010 enm_alive  in  N_ENM  enemy e alive when bit e = 1.
REQ-011 bomb  in  1  clear all bullets this cycle.
REQ-012 bul_x, bul_y  out  10*NB each  packed bullet positions; index b = 3e+k, k=0 straight, k=1 down-left, k=2 down-right.
REQ-013 bul_act  out  NB  bullet b in flight.
REQ-014 shot  out  1  player hit, one-cycle pulse.
REQ-015 hit_cnt  out  8  total hits, saturating.

Function
REQ-016 All outputs and all state SHALL be registers updated on posedge clk22 only.
REQ-017 Each bullet SHALL be IDLE (bul_act=0, bul_x=bul_y=0) or FLY (bul_act=1).
REQ-018 Each enemy SHALL own a down-counter cd[e] (8 bits), decremented each cycle while nonzero.
REQ-019 When cd[e]=0 and enm_alive[e]=1, each IDLE bullet of enemy e SHALL enter FLY at (enmx[e], enmy[e]) and cd[e] SHALL load FIRE_PERIOD-1; FLY bullets of e are untouched.
REQ-020 When cd[e]=0 and enm_alive[e]=0, no spawn; cd[e] stays 0.
REQ-021 FLY bullet motion per cycle: k=0 y+SPD_V; k=1 x-SPD_D, y+SPD_D; k=2 x+SPD_D, y+SPD_D.
REQ-022 Hit test on current registered position, 11-bit unsigned arithmetic, no wrap: reimux-10 < x < reimux+12 and reimuy-11 < y < reimuy+11; terms with reimux<10 or reimuy<11 SHALL use 0 as lower bound.
REQ-023 FLY bullet that hits SHALL go IDLE next cycle; shot SHALL be 1 in that next cycle only, regardless of how many bullets hit together.
REQ-024 Non-hitting FLY bullet whose computed next position has x<X_MIN, x>X_MAX or y>Y_MAX (11-bit signed compare) SHALL go IDLE instead of moving.
REQ-025 Hit priority over out-of-bounds; spawn (REQ-019) applies only to bullets IDLE at the start of the cycle.
REQ-026 Bullets in FLY SHALL continue after their enemy's enm_alive drops to 0.
REQ-027 hit_cnt SHALL increment by 1 per shot pulse, holding at 255.
REQ-028 bomb=1 SHALL force all bullets IDLE next cycle, suppress shot and hit_cnt increment that cycle, and load all cd[e] with FIRE_PERIOD-1.

Reset
REQ-029 rst=1 SHALL set all bullets IDLE with positions 0, shot=0, hit_cnt=0, cd[e]=e (staggered first volley), overriding bomb and all other inputs.
REQ-030 rst asserted mid-flight SHALL clear state on the same edge with no shot pulse afterward.

Verification
REQ-031 N_ENM=4, enemy0 alive at (100,50), player (300,400), rst low at cycle 0 -> cycle 1: bullets 0..2 FLY at (100,50); cycle 2: (100,60),(93,57),(107,57).
REQ-032 Straight bullet at (200,390) FLY, player (200,400) -> next cycle bul_act[b]=0, shot=1, hit_cnt=1; cycle after shot=0.
REQ-033 Two bullets hitting same cycle -> single shot pulse, hit_cnt +1.
REQ-034 Down-left bullet at (12,100) -> next x=5 < 8 -> IDLE, position 0, no shot.
REQ-035 Enemy1 alive then enm_alive[1]=0 while its bullets fly -> bullets keep moving; no respawn after cd[1] reaches 0.
REQ-036 bomb=1 with 6 bullets FLY and one hitting -> all bul_act=0, shot=0, hit_cnt unchanged; first respawn FIRE_PERIOD cycles later.

Source files
------------

// File: rtl/enm_bullet_pool.sv
// Enemy bullet pool: three bullets per enemy, periodic volleys,
// straight/diagonal motion, player hit detection and bomb clear.
module enm_bullet_pool #(
    parameter int N_ENM       = 4,
    parameter int FIRE_PERIOD = 16,
    parameter int SPD_V       = 10,
    parameter int SPD_D       = 7,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 432,
    parameter int Y_MAX       = 472,
    localparam int NB         = 3 * N_ENM
) (
    input  logic                  clk22,
    input  logic                  rst,
    input  logic [9:0]            reimux,
    input  logic [9:0]            reimuy,
    input  logic [10*N_ENM-1:0]   enmx,
    input  logic [10*N_ENM-1:0]   enmy,
    input  logic [N_ENM-1:0]      enm_alive,
    input  logic                  bomb,
    output logic [10*NB-1:0]      bul_x,
    output logic [10*NB-1:0]      bul_y,
    output logic [NB-1:0]         bul_act,
    output logic                  shot,
    output logic [7:0]            hit_cnt
);

    typedef enum logic {
        B_IDLE = 1'b0,
        B_FLY  = 1'b1
    } bst_t;

    localparam logic [7:0]         CD_LOAD = 8'(FIRE_PERIOD - 1);
    localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
    localparam logic signed [11:0] YMAX_S  = 12'(Y_MAX);

    bst_t        st    [NB];
    bst_t        st_n  [NB];
    logic [9:0]  px    [NB];
    logic [9:0]  py    [NB];
    logic [9:0]  px_n  [NB];
    logic [9:0]  py_n  [NB];
    logic [7:0]  cd    [N_ENM];
    logic [7:0]  cd_n  [N_ENM];
    logic        fire  [N_ENM];
    logic        hit   [NB];
    logic        oob   [NB];
    logic signed [11:0] nx [NB];
    logic signed [11:0] ny [NB];
    logic        any_hit;
    logic        shot_n;
    logic [7:0]  cnt_n;

    logic [10:0] lo_x, hi_x, lo_y, hi_y;

    // Hit window lower bounds clamp at 0 instead of wrapping.
    always_comb begin
        lo_x = (reimux < 10'd10) ? 11'd0 : ({1'b0, reimux} - 11'd10);
        hi_x = {1'b0, reimux} + 11'd12;
        lo_y = (reimuy < 10'd11) ? 11'd0 : ({1'b0, reimuy} - 11'd11);
        hi_y = {1'b0, reimuy} + 11'd11;
    end

    always_comb begin
        any_hit = 1'b0;
        for (int b = 0; b < NB; b++) begin
            hit[b] = (st[b] == B_FLY) &&
                     ({1'b0, px[b]} > lo_x) && ({1'b0, px[b]} < hi_x) &&
                     ({1'b0, py[b]} > lo_y) && ({1'b0, py[b]} < hi_y);
            any_hit = any_hit | hit[b];
            nx[b] = {2'b00, px[b]};
            ny[b] = {2'b00, py[b]};
            if (b % 3 == 0) begin
                ny[b] = {2'b00, py[b]} + 12'(SPD_V);
            end else if (b % 3 == 1) begin
                nx[b] = {2'b00, px[b]} - 12'(SPD_D);
                ny[b] = {2'b00, py[b]} + 12'(SPD_D);
            end else begin
                nx[b] = {2'b00, px[b]} + 12'(SPD_D);
                ny[b] = {2'b00, py[b]} + 12'(SPD_D);
            end
            oob[b] = (nx[b] < XMIN_S) || (nx[b] > XMAX_S) ||
                     (ny[b] > YMAX_S);
        end
    end

    always_comb begin
        for (int e = 0; e < N_ENM; e++) begin
            fire[e] = (cd[e] == 8'd0) && enm_alive[e];
            cd_n[e] = cd[e];
            if (bomb) begin
                cd_n[e] = CD_LOAD;
            end else if (cd[e] != 8'd0) begin
                cd_n[e] = cd[e] - 8'd1;
            end else if (enm_alive[e]) begin
                cd_n[e] = CD_LOAD;
            end
        end
    end

    always_comb begin
        shot_n = any_hit && !bomb;
        cnt_n  = hit_cnt;
        if (shot_n && hit_cnt != 8'd255) begin
            cnt_n = hit_cnt + 8'd1;
        end
        for (int b = 0; b < NB; b++) begin
            st_n[b] = st[b];
            px_n[b] = px[b];
            py_n[b] = py[b];
            if (bomb) begin
                st_n[b] = B_IDLE;
                px_n[b] = 10'd0;
                py_n[b] = 10'd0;
            end else if (st[b] == B_FLY) begin
                // A hit wins over leaving the field.
                if (hit[b] || oob[b]) begin
                    st_n[b] = B_IDLE;
                    px_n[b] = 10'd0;
                    py_n[b] = 10'd0;
                end else begin
                    px_n[b] = nx[b][9:0];
                    py_n[b] = ny[b][9:0];
                end
            end else if (fire[b / 3]) begin
                st_n[b] = B_FLY;
                px_n[b] = enmx[10*(b/3) +: 10];
                py_n[b] = enmy[10*(b/3) +: 10];
            end
        end
    end

    always_ff @(posedge clk22) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                st[b] <= B_IDLE;
                px[b] <= 10'd0;
                py[b] <= 10'd0;
            end
            // Staggered countdowns so enemies do not all fire together.
            for (int e = 0; e < N_ENM; e++) begin
                cd[e] <= 8'(e);
            end
            shot    <= 1'b0;
            hit_cnt <= 8'd0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                st[b] <= st_n[b];
                px[b] <= px_n[b];
                py[b] <= py_n[b];
            end
            for (int e = 0; e < N_ENM; e++) begin
                cd[e] <= cd_n[e];
            end
            shot    <= shot_n;
            hit_cnt <= cnt_n;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_out
        assign bul_x[10*b +: 10] = px[b];
        assign bul_y[10*b +: 10] = py[b];
        assign bul_act[b]        = (st[b] == B_FLY);
    end

endmodule

// File: tb/tb_enm_bullet_pool.sv
// Bench for enm_bullet_pool: directed scenarios plus random
// stimulus against an array-based reference model.
module tb_enm_bullet_pool;

    localparam int N  = 4;
    localparam int NB = 3 * N;
    localparam int FP = 16;
    localparam int SV = 10;
    localparam int SD = 7;
    localparam int XL = 8;
    localparam int XH = 432;
    localparam int YH = 472;

    logic              clk22 = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        reimux = '0;
    logic [9:0]        reimuy = '0;
    logic [10*N-1:0]   enmx = '0;
    logic [10*N-1:0]   enmy = '0;
    logic [N-1:0]      enm_alive = '0;
    logic              bomb = 1'b0;
    logic [10*NB-1:0]  bul_x;
    logic [10*NB-1:0]  bul_y;
    logic [NB-1:0]     bul_act;
    logic              shot;
    logic [7:0]        hit_cnt;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit ma [NB];
    int mx [NB];
    int my [NB];
    int mcd [N];
    bit msh;
    int mhc;

    enm_bullet_pool #(
        .N_ENM(N), .FIRE_PERIOD(FP), .SPD_V(SV), .SPD_D(SD),
        .X_MIN(XL), .X_MAX(XH), .Y_MAX(YH)
    ) dut (
        .clk22(clk22), .rst(rst), .reimux(reimux), .reimuy(reimuy),
        .enmx(enmx), .enmy(enmy), .enm_alive(enm_alive), .bomb(bomb),
        .bul_x(bul_x), .bul_y(bul_y), .bul_act(bul_act),
        .shot(shot), .hit_cnt(hit_cnt)
    );

    always #5 clk22 = ~clk22;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_box(int x, int y);
        int px, py, lx, ly;
        px = int'(reimux);
        py = int'(reimuy);
        lx = (px - 10 < 0) ? 0 : px - 10;
        ly = (py - 11 < 0) ? 0 : py - 11;
        return (x > lx) && (x < px + 12) && (y > ly) && (y < py + 11);
    endfunction

    task automatic clear_b(int b);
        ma[b] = 0;
        mx[b] = 0;
        my[b] = 0;
    endtask

    task automatic model_step();
        int hits, e, k, x2, y2;
        int dx[3];
        int dy[3];
        dx = '{0, -SD, SD};
        dy = '{SV, SD, SD};
        if (rst) begin
            for (int b = 0; b < NB; b++) clear_b(b);
            for (int i = 0; i < N; i++) mcd[i] = i;
            msh = 0;
            mhc = 0;
        end else if (bomb) begin
            for (int b = 0; b < NB; b++) clear_b(b);
            for (int i = 0; i < N; i++) mcd[i] = FP - 1;
            msh = 0;
        end else begin
            hits = 0;
            for (int b = 0; b < NB; b++) begin
                e = b / 3;
                k = b % 3;
                if (ma[b]) begin
                    if (in_box(mx[b], my[b])) begin
                        clear_b(b);
                        hits++;
                    end else begin
                        x2 = mx[b] + dx[k];
                        y2 = my[b] + dy[k];
                        if (x2 < XL || x2 > XH || y2 > YH) clear_b(b);
                        else begin
                            mx[b] = x2;
                            my[b] = y2;
                        end
                    end
                end else if (mcd[e] == 0 && enm_alive[e]) begin
                    ma[b] = 1;
                    mx[b] = int'(enmx[10*e +: 10]);
                    my[b] = int'(enmy[10*e +: 10]);
                end
            end
            msh = (hits > 0);
            if (msh && mhc < 255) mhc++;
            for (int i = 0; i < N; i++) begin
                if (mcd[i] > 0) mcd[i]--;
                else if (enm_alive[i]) mcd[i] = FP - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk22);
        model_step();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        logic [10*NB-1:0] vx, vy;
        logic [NB-1:0] va;
        for (int b = 0; b < NB; b++) begin
            va[b] = ma[b];
            vx[10*b +: 10] = 10'(mx[b]);
            vy[10*b +: 10] = 10'(my[b]);
        end
        chk({tag, ".act"}, 128'(bul_act), 128'(va));
        chk({tag, ".x"}, 128'(bul_x), 128'(vx));
        chk({tag, ".y"}, 128'(bul_y), 128'(vy));
        chk({tag, ".shot"}, 128'(shot), 128'(msh));
        chk({tag, ".cnt"}, 128'(hit_cnt), 128'(mhc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic setup(int ex, int ey, int rx, int ry);
        enmx = '0;
        enmy = '0;
        enmx[9:0] = 10'(ex);
        enmy[9:0] = 10'(ey);
        enm_alive = 4'b0001;
        reimux = 10'(rx);
        reimuy = 10'(ry);
    endtask

    initial begin
        // reset overrides bomb
        bomb = 1'b1;
        enm_alive = '1;
        do_reset();
        bomb = 1'b0;
        chk("rst.act", 128'(bul_act), 128'(0));
        chk("rst.x", 128'(bul_x), 128'(0));
        chk("rst.shot", 128'(shot), 128'(0));
        chk("rst.cnt", 128'(hit_cnt), 128'(0));

        // first volley and one step of motion
        rst = 1'b1;
        setup(100, 50, 300, 400);
        do_reset();
        tick();
        chk("v1.act", 128'(bul_act[2:0]), 128'(3'b111));
        chk("v1.x", 128'(bul_x[29:0]), 128'({10'd100, 10'd100, 10'd100}));
        chk("v1.y", 128'(bul_y[29:0]), 128'({10'd50, 10'd50, 10'd50}));
        tick();
        chk("v2.x", 128'(bul_x[29:0]), 128'({10'd107, 10'd93, 10'd100}));
        chk("v2.y", 128'(bul_y[29:0]), 128'({10'd57, 10'd57, 10'd60}));

        // three bullets hit together: one pulse, one count
        rst = 1'b1;
        setup(200, 390, 200, 400);
        do_reset();
        tick();
        chk("hit.spawn", 128'(bul_act[2:0]), 128'(3'b111));
        tick();
        chk("hit.act", 128'(bul_act[2:0]), 128'(3'b000));
        chk("hit.shot", 128'(shot), 128'(1));
        chk("hit.cnt", 128'(hit_cnt), 128'(1));
        tick();
        chk("hit.shot0", 128'(shot), 128'(0));
        chk("hit.cnt1", 128'(hit_cnt), 128'(1));

        // left edge exit
        rst = 1'b1;
        setup(12, 100, 400, 460);
        do_reset();
        tick();
        tick();
        chk("oob.act", 128'(bul_act[2:0]), 128'(3'b101));
        chk("oob.x", 128'(bul_x[19:10]), 128'(0));
        chk("oob.y", 128'(bul_y[19:10]), 128'(0));
        chk("oob.shot", 128'(shot), 128'(0));

        // bomb clears, volley resumes FP cycles later
        rst = 1'b1;
        setup(200, 100, 400, 460);
        do_reset();
        tick();
        tick();
        bomb = 1'b1;
        tick();
        bomb = 1'b0;
        chk("bomb.act", 128'(bul_act), 128'(0));
        chk("bomb.shot", 128'(shot), 128'(0));
        repeat (FP - 1) tick();
        chk("bomb.wait", 128'(bul_act[2:0]), 128'(3'b000));
        tick();
        chk("bomb.refire", 128'(bul_act[2:0]), 128'(3'b111));
        cmp_model("dir");

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            bomb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) enm_alive = 4'($urandom);
            for (int e = 0; e < N; e++) begin
                if ($urandom_range(0, 3) == 0) begin
                    enmx[10*e +: 10] = 10'($urandom_range(0, 440));
                    enmy[10*e +: 10] = 10'($urandom_range(0, 300));
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    reimux = enmx[9:0];
                    reimuy = 10'($urandom_range(20, 470));
                end else begin
                    reimux = 10'($urandom_range(0, 450));
                    reimuy = 10'($urandom_range(0, 480));
                end
            end
            tick();
            cmp_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
